// File: rtl/lc3_dmem_responder.sv
// Data-memory responder for the LC3 data cache: services 4-word burst reads and
// single-word write-through writes with configurable, stallable access latency.
module lc3_dmem_responder #(
  parameter int unsigned RD_LATENCY = 4,
  parameter int unsigned WR_LATENCY = 2,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rrqst,
  input  logic        wrqst,
  input  logic        rdacpt,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  output logic        rrdy,
  output logic        rdrdy,
  output logic [15:0] dout,
  output logic        wacpt,
  output logic        busy
);

  localparam int unsigned Depth     = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  RdCntInit = 4'(RD_LATENCY - 1);
  localparam logic [3:0]  WrCntInit = 4'(WR_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdLat,
    StRdXfer,
    StWrLat,
    StWrAck
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            off_q, off_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  rrdy_q, rrdy_d;
  logic                  rdrdy_q, rdrdy_d;
  logic                  wacpt_q, wacpt_d;
  logic                  busy_q, busy_d;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] rd_idx;

  logic [15:0] mem_q [Depth];

  // Address bits above the array index only alias; they carry no state.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[15:DEPTH_LOG2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rrdy_d  = 1'b0;
    rdrdy_d = 1'b0;
    wacpt_d = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wrqst) begin
          addr_d  = addr[DEPTH_LOG2-1:0];
          wdata_d = din;
          cnt_d   = WrCntInit;
          state_d = StWrLat;
        end else if (rrqst) begin
          // Bursts always start at the aligned block base.
          addr_d  = {addr[DEPTH_LOG2-1:2], 2'b00};
          cnt_d   = RdCntInit;
          rrdy_d  = 1'b1;
          state_d = StRdLat;
        end
      end

      StRdLat: begin
        if (cnt_q == 4'd0) begin
          off_d   = 2'd0;
          rdrdy_d = 1'b1;
          state_d = StRdXfer;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StRdXfer: begin
        rdrdy_d = 1'b1;
        if (rdacpt) begin
          off_d = off_q + 2'd1;
          if (off_q == 2'd3) begin
            rdrdy_d = 1'b0;
            state_d = StIdle;
          end
        end
      end

      StWrLat: begin
        if (cnt_q == 4'd0) begin
          mem_we  = 1'b1;
          wacpt_d = 1'b1;
          state_d = StWrAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StWrAck: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      off_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      rrdy_q  <= 1'b0;
      rdrdy_q <= 1'b0;
      wacpt_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rrdy_q  <= rrdy_d;
      rdrdy_q <= rdrdy_d;
      wacpt_q <= wacpt_d;
      busy_q  <= busy_d;
    end
  end

  // Array is deliberately not reset; a write only lands once WR_LAT expires.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign rd_idx = {addr_q[DEPTH_LOG2-1:2], off_q};

  assign rrdy  = rrdy_q;
  assign rdrdy = rdrdy_q;
  assign wacpt = wacpt_q;
  assign busy  = busy_q;
  assign dout  = rdrdy_q ? mem_q[rd_idx] : 16'h0000;

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Self-checking bench for lc3_dmem_responder: directed scenarios plus randomized
// traffic checked against a flat array model of memory.
module tb_lc3_dmem_responder;

  localparam int RdLat     = 4;
  localparam int WrLat     = 2;
  localparam int DepthLog2 = 12;
  localparam int Depth     = 4096;

  logic        clock  = 1'b0;
  logic        reset  = 1'b0;
  logic        rrqst  = 1'b0;
  logic        wrqst  = 1'b0;
  logic        rdacpt = 1'b0;
  logic [15:0] addr   = 16'h0000;
  logic [15:0] din    = 16'h0000;
  logic        rrdy, rdrdy, wacpt, busy;
  logic [15:0] dout;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] model [Depth];

  // Results of the most recent burst collection.
  logic [15:0] rd_w [4];
  logic [15:0] rd_held [8];
  logic        rd_held_v [8];
  int          rd_rrdy_cnt, rd_first, rd_first_xfer, rd_last_xfer;
  logic        rd_end_busy, rd_end_rdrdy;
  bit          rd_timeout;

  lc3_dmem_responder #(
    .RD_LATENCY(RdLat),
    .WR_LATENCY(WrLat),
    .DEPTH_LOG2(DepthLog2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rrqst (rrqst),
    .wrqst (wrqst),
    .rdacpt(rdacpt),
    .addr  (addr),
    .din   (din),
    .rrdy  (rrdy),
    .rdrdy (rdrdy),
    .dout  (dout),
    .wacpt (wacpt),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic logic [15:0] ref_word(input logic [15:0] a, input int k);
    int base;
    base = (int'(a) % Depth) / 4 * 4;
    return model[base + k];
  endfunction

  task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                          output int lat, output bit tail_ok);
    @(posedge clock); #1;
    wrqst = 1'b1; addr = a; din = d;
    @(posedge clock); #1;
    addr = 16'($urandom); din = 16'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (wacpt) begin
        lat = i; wrqst = 1'b0;
        break;
      end
    end
    wrqst = 1'b0;
    @(posedge clock); #1;
    tail_ok = !wacpt && !busy;
    model[int'(a) % Depth] = d;
  endtask

  // Entered at the sample just after the read-capture edge.
  task automatic collect_burst(input int stall_word, input int stall_len, input bit rnd_stall);
    int  c, nw, stalls;
    bit  prev_stall;
    c = 0; nw = 0; stalls = 0; prev_stall = 0;
    rd_rrdy_cnt = 0; rd_first = -1; rd_first_xfer = -1; rd_last_xfer = -1;
    while (nw < 4 && c < RdLat + 100) begin
      if (rrdy) begin
        rd_rrdy_cnt++; rrqst = 1'b0; addr = 16'($urandom);
      end
      if (prev_stall) begin
        rd_held[stalls-1] = dout; rd_held_v[stalls-1] = rdrdy;
      end
      prev_stall = 0;
      rdacpt = 1'b0;
      if (rdrdy) begin
        if (rd_first < 0) rd_first = c;
        if (nw == stall_word && stalls < stall_len) begin
          stalls++; prev_stall = 1;
        end else if (rnd_stall && $urandom_range(0, 2) == 0) begin
          rdacpt = 1'b0;
        end else begin
          rdacpt = 1'b1; rd_w[nw] = dout;
          if (rd_first_xfer < 0) rd_first_xfer = c + 1;
          rd_last_xfer = c + 1;
          nw++;
        end
      end
      @(posedge clock); #1;
      c++;
    end
    rdacpt = 1'b0; rrqst = 1'b0;
    rd_end_busy = busy; rd_end_rdrdy = rdrdy;
    rd_timeout = (nw < 4);
  endtask

  task automatic do_read(input logic [15:0] a, input int stall_word, input int stall_len,
                         input bit rnd_stall);
    @(posedge clock); #1;
    rrqst = 1'b1; addr = a;
    @(posedge clock); #1;
    collect_burst(stall_word, stall_len, rnd_stall);
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (rrdy !== 1'b0) begin errors++; $display("FAIL reset_rrdy got=%b want=0", rrdy); end
    vectors++; if (rdrdy !== 1'b0) begin errors++; $display("FAIL reset_rdrdy got=%b want=0", rdrdy); end
    vectors++; if (wacpt !== 1'b0) begin errors++; $display("FAIL reset_wacpt got=%b want=0", wacpt); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    vectors++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout got=%h want=0000", dout); end
    reset = 1'b1;
  endtask

  task automatic test_fill();
    int lat; bit tail;
    for (int i = 0; i < Depth; i++) begin
      do_write(16'(i), 16'($urandom), lat, tail);
      vectors++;
      if (lat !== WrLat || !tail) begin
        errors++;
        $display("FAIL fill_write addr=%h lat got=%0d want=%0d tail_ok=%b", i, lat, WrLat, tail);
      end
    end
  endtask

  task automatic test_burst_read();
    int lat; bit tail;
    logic [15:0] exp [4];
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333; exp[3] = 16'h4444;
    for (int i = 0; i < 4; i++) do_write(16'h0040 + 16'(i), exp[i], lat, tail);
    do_read(16'h0042, -1, 0, 0);
    vectors++; if (rd_rrdy_cnt !== 1) begin errors++; $display("FAIL burst_rrdy_pulses got=%0d want=1", rd_rrdy_cnt); end
    vectors++; if (rd_first !== RdLat) begin errors++; $display("FAIL burst_rdrdy_latency got=%0d want=%0d", rd_first, RdLat); end
    vectors++;
    if (rd_first_xfer !== RdLat + 1 || rd_last_xfer !== RdLat + 4) begin
      errors++;
      $display("FAIL burst_xfer_edges got=%0d..%0d want=%0d..%0d", rd_first_xfer, rd_last_xfer, RdLat + 1, RdLat + 4);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd_w[i] !== exp[i]) begin errors++; $display("FAIL burst_word%0d got=%h want=%h", i, rd_w[i], exp[i]); end
    end
    vectors++;
    if (rd_end_busy !== 1'b0 || rd_end_rdrdy !== 1'b0 || rd_timeout) begin
      errors++;
      $display("FAIL burst_end busy=%b rdrdy=%b timeout=%b want 0/0/0", rd_end_busy, rd_end_rdrdy, rd_timeout);
    end
  endtask

  task automatic test_stalled_read();
    do_read(16'h0042, 1, 3, 0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rd_held[i] !== 16'h2222 || rd_held_v[i] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d dout=%h rdrdy=%b want 2222/1", i, rd_held[i], rd_held_v[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd_w[i] !== ref_word(16'h0040, i)) begin
        errors++; $display("FAIL stall_word%0d got=%h want=%h", i, rd_w[i], ref_word(16'h0040, i));
      end
    end
    vectors++;
    if (rd_last_xfer - rd_first_xfer !== 6 || rd_end_busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_span got=%0d busy=%b want 6/0", rd_last_xfer - rd_first_xfer, rd_end_busy);
    end
  endtask

  task automatic test_write_readback();
    int lat; bit tail;
    do_write(16'h0101, 16'hBEEF, lat, tail);
    vectors++;
    if (lat !== 2 || !tail) begin errors++; $display("FAIL wb_wacpt lat got=%0d want=2 tail_ok=%b", lat, tail); end
    do_read(16'h0100, -1, 0, 0);
    vectors++;
    if (rd_w[1] !== 16'hBEEF) begin errors++; $display("FAIL wb_word1 got=%h want=beef", rd_w[1]); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd_w[i] !== ref_word(16'h0100, i)) begin
        errors++; $display("FAIL wb_word%0d got=%h want=%h", i, rd_w[i], ref_word(16'h0100, i));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] a, d;
    int wac_c, rr_c;
    bit early_rrdy;
    a = 16'($urandom); d = 16'($urandom);
    @(posedge clock); #1;
    wrqst = 1'b1; rrqst = 1'b1; addr = a; din = d;
    @(posedge clock); #1;
    early_rrdy = rrdy; wac_c = -1; rr_c = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (wacpt && wac_c < 0) begin wac_c = c; wrqst = 1'b0; end
      if (rrdy) begin rr_c = c; break; end
    end
    wrqst = 1'b0;
    model[int'(a) % Depth] = d;
    vectors++;
    if (early_rrdy !== 1'b0 || wac_c !== WrLat) begin
      errors++; $display("FAIL simul_write_first rrdy0=%b wacpt_at=%0d want 0/%0d", early_rrdy, wac_c, WrLat);
    end
    vectors++;
    if (rr_c !== WrLat + 2) begin errors++; $display("FAIL simul_rrdy_at got=%0d want=%0d", rr_c, WrLat + 2); end
    if (rr_c < 0) rrqst = 1'b0;
    collect_burst(-1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd_w[i] !== ref_word(a, i)) begin
        errors++; $display("FAIL simul_word%0d got=%h want=%h", i, rd_w[i], ref_word(a, i));
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    vectors++;
    if ({rrdy, rdrdy, wacpt, busy} !== 4'b0000 || dout !== 16'h0000) begin
      errors++;
      $display("FAIL %s rrdy=%b rdrdy=%b wacpt=%b busy=%b dout=%h want all 0", tag, rrdy, rdrdy, wacpt,
               busy, dout);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    @(posedge clock); #1;
    rrqst = 1'b1; addr = 16'h0040;
    @(posedge clock); #1;
    rrqst = 1'b0; rdacpt = 1'b1; n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      if (rdrdy) n++;
      @(posedge clock); #1;
    end
    vectors++;
    if (rdrdy !== 1'b1 || n != 2) begin errors++; $display("FAIL rstrd_pre rdrdy=%b n=%0d want 1/2", rdrdy, n); end
    #3 reset = 1'b0; rdacpt = 1'b0;
    #1 check_outputs_zero("rstrd_outputs");
    #2 reset = 1'b1;
    do_read(16'h0040, -1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd_w[i] !== ref_word(16'h0040, i)) begin
        errors++; $display("FAIL rstrd_word%0d got=%h want=%h", i, rd_w[i], ref_word(16'h0040, i));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    @(posedge clock); #1;
    wrqst = 1'b1; addr = 16'h0041; din = 16'hDEAD;
    @(posedge clock); #1;
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstwr_pre busy=%b want=1", busy); end
    #3 reset = 1'b0; wrqst = 1'b0;
    #1 check_outputs_zero("rstwr_outputs");
    #2 reset = 1'b1;
    do_read(16'h0040, -1, 0, 0);
    vectors++;
    if (rd_w[1] !== 16'h2222) begin errors++; $display("FAIL rstwr_target got=%h want=2222", rd_w[1]); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd_w[i] !== ref_word(16'h0040, i)) begin
        errors++; $display("FAIL rstwr_word%0d got=%h want=%h", i, rd_w[i], ref_word(16'h0040, i));
      end
    end
  endtask

  task automatic test_aliasing();
    int lat; bit tail;
    do_write(16'h1003, 16'hA5A5, lat, tail);
    do_read(16'h0000, -1, 0, 0);
    vectors++;
    if (rd_w[3] !== 16'hA5A5) begin errors++; $display("FAIL alias_word3 got=%h want=a5a5", rd_w[3]); end
    vectors++;
    if (rd_w[0] !== ref_word(16'h0000, 0)) begin
      errors++; $display("FAIL alias_word0 got=%h want=%h", rd_w[0], ref_word(16'h0000, 0));
    end
  endtask

  task automatic test_random();
    int lat; bit tail;
    logic [15:0] a;
    for (int t = 0; t < 60; t++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, 16'($urandom), lat, tail);
        vectors++;
        if (lat !== WrLat || !tail) begin
          errors++; $display("FAIL rnd_write addr=%h lat got=%0d want=%0d tail_ok=%b", a, lat, WrLat, tail);
        end
      end else begin
        do_read(a, -1, 0, 1);
        vectors++;
        if (rd_rrdy_cnt !== 1 || rd_first !== RdLat || rd_timeout) begin
          errors++;
          $display("FAIL rnd_read_timing addr=%h rrdy=%0d first=%0d timeout=%b want 1/%0d/0", a, rd_rrdy_cnt,
                   rd_first, rd_timeout, RdLat);
        end
        for (int i = 0; i < 4; i++) begin
          vectors++;
          if (rd_w[i] !== ref_word(a, i)) begin
            errors++; $display("FAIL rnd_word addr=%h k=%0d got=%h want=%h", a, i, rd_w[i], ref_word(a, i));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_burst_read();
    test_stalled_read();
    test_write_readback();
    test_simultaneous();
    test_reset_mid_read();
    test_reset_mid_write();
    test_aliasing();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
